// File: rtl/aes_inv_key_expand.sv
// Inverse AES-128 key schedule: loads K10, emits K10..K0 over valid/ready, one key per cycle.
// Latency 1 cycle from start; round_key/rk_round hold while rk_ready=0, done pulses after K0.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = t[7] ? ({t[6:0], 1'b0} ^ 8'h1b) : {t[6:0], 1'b0};
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8); zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

module aes_inv_key_expand #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] last_key,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       rk_round,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  localparam logic [3:0] LAST_RND = 4'(NR);

  logic [1:0]       state;
  logic [31:0]      a0, a1, a2, a3;
  logic [31:0]      b0, b1, b2, b3;
  logic [31:0]      rot, sub;
  logic [7:0]       rcon;
  logic [KEY_W-1:0] prev_key;

  assign a0 = round_key[127:96];
  assign a1 = round_key[95:64];
  assign a2 = round_key[63:32];
  assign a3 = round_key[31:0];

  assign b3  = a3 ^ a2;
  assign b2  = a2 ^ a1;
  assign b1  = a1 ^ a0;
  assign rot = {b3[23:0], b3[31:24]};

  aes_sbox u_sb0 (.a(rot[31:24]), .s(sub[31:24]));
  aes_sbox u_sb1 (.a(rot[23:16]), .s(sub[23:16]));
  aes_sbox u_sb2 (.a(rot[15:8]),  .s(sub[15:8]));
  aes_sbox u_sb3 (.a(rot[7:0]),   .s(sub[7:0]));

  // Rcon is indexed by the round being undone, i.e. the current rk_round.
  always_comb begin
    rcon = 8'h00;
    case (rk_round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign b0       = a0 ^ sub ^ {rcon, 24'h0};
  assign prev_key = {b0, b1, b2, b3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_key <= '0;
      rk_round  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            round_key <= last_key;
            rk_round  <= LAST_RND;
            state     <= RUN;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (rk_round == 4'd0) begin
              state <= FIN;
            end else begin
              round_key <= prev_key;
              rk_round  <= rk_round - 4'd1;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rk_valid = (state == RUN);
  assign busy     = (state != IDLE);
  assign done     = (state == FIN);

endmodule
